// File: rtl/muldiv_div_unit.sv
// rtl/muldiv_div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit
// Restoring divide on operand magnitudes; sign fix-up folded into the final CALC step.
module muldiv_div_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_,
    input  logic            flush_,
    input  logic [2:0]      funct3_,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic [4:0]      rd_in_,
    output logic            busy_,
    output logic            done_,
    output logic [XLEN-1:0] result_,
    output logic [4:0]      rd_out_
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem, r_quo, r_dvs;
    logic            r_is_rem, r_neg_q, r_neg_r;
    logic [4:0]      r_rd, r_rd_out;
    logic [XLEN-1:0] r_result;

    logic            w_signed, w_is_rem, w_accept, w_div0, w_ovf, w_special, w_last;
    logic [XLEN-1:0] w_special_res, w_abs1, w_abs2;
    logic [XLEN-1:0] w_step_rem, w_step_quo, w_fix_q, w_fix_r, w_calc_res;

    assign w_signed  = (funct3_ == 3'b100) || (funct3_ == 3'b110);
    assign w_is_rem  = (funct3_ == 3'b110) || (funct3_ == 3'b111);
    assign w_accept  = (r_state == S_IDLE) && start_ && !flush_;
    assign w_div0    = (rs2_value == '0);
    assign w_ovf     = w_signed && (rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_value == '1);
    assign w_special = w_div0 || w_ovf;
    // Overflow case: DIV returns the dividend (most negative value), REM returns 0.
    assign w_special_res = w_div0 ? (w_is_rem ? rs1_value : '1)
                                  : (w_is_rem ? '0 : rs1_value);
    assign w_abs1 = (w_signed && rs1_value[XLEN-1]) ? -rs1_value : rs1_value;
    assign w_abs2 = (w_signed && rs2_value[XLEN-1]) ? -rs2_value : rs2_value;
    assign w_last = (r_cnt == CW'(N - 1));

    always_comb begin
        logic [XLEN-1:0] v_rem;
        logic [XLEN-1:0] v_quo;
        logic [XLEN:0]   v_sh;
        v_rem = r_rem;
        v_quo = r_quo;
        v_sh  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            v_sh  = {v_rem, v_quo[XLEN-1]};
            v_quo = {v_quo[XLEN-2:0], 1'b0};
            if (v_sh >= {1'b0, r_dvs}) begin
                v_sh     = v_sh - {1'b0, r_dvs};
                v_quo[0] = 1'b1;
            end
            v_rem = v_sh[XLEN-1:0];
        end
        w_step_rem = v_rem;
        w_step_quo = v_quo;
    end

    assign w_fix_q    = r_neg_q ? -w_step_quo : w_step_quo;
    assign w_fix_r    = r_neg_r ? -w_step_rem : w_step_rem;
    assign w_calc_res = r_is_rem ? w_fix_r : w_fix_q;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_)      w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy_   = (r_state != S_IDLE);
    assign done_   = (r_state == S_DONE) && !flush_;
    assign result_ = r_result;
    assign rd_out_ = r_rd_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rd     <= '0;
            r_rd_out <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_rem <= w_is_rem;
                r_neg_q  <= w_signed && (rs1_value[XLEN-1] ^ rs2_value[XLEN-1]);
                r_neg_r  <= w_signed && rs1_value[XLEN-1];
                r_rd     <= rd_in_;
                r_cnt    <= '0;
                r_rem    <= '0;
                r_quo    <= w_abs1;
                r_dvs    <= w_abs2;
                if (w_special) begin
                    r_result <= w_special_res;
                    r_rd_out <= rd_in_;
                end
            end else if (r_state == S_CALC && !flush_) begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= w_calc_res;
                    r_rd_out <= r_rd;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_div_unit.sv
// tb/tb_muldiv_div_unit.sv - randomized self-checking bench for muldiv_div_unit
// Two instances (1 and 4 bits per cycle) checked every cycle against a transaction-level model.
module tb_muldiv_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_s  [2];
    logic        flush_s  [2];
    logic [2:0]  f3_s     [2];
    logic [31:0] a_s      [2];
    logic [31:0] b_s      [2];
    logic [4:0]  rd_s     [2];
    logic        busy_o   [2];
    logic        done_o   [2];
    logic [31:0] result_o [2];
    logic [4:0]  rd_o     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_div_unit u_dut1 (
        .clk(clk), .rst(rst), .start_(start_s[0]), .flush_(flush_s[0]), .funct3_(f3_s[0]),
        .rs1_value(a_s[0]), .rs2_value(b_s[0]), .rd_in_(rd_s[0]),
        .busy_(busy_o[0]), .done_(done_o[0]), .result_(result_o[0]), .rd_out_(rd_o[0])
    );

    muldiv_div_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_(start_s[1]), .flush_(flush_s[1]), .funct3_(f3_s[1]),
        .rs1_value(a_s[1]), .rs2_value(b_s[1]), .rd_in_(rd_s[1]),
        .busy_(busy_o[1]), .done_(done_o[1]), .result_(result_o[1]), .rd_out_(rd_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int calc_cycles(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (f == 3'b100) || (f == 3'b110);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit sgn, rem;
        longint sa, sb, q, r;
        sgn = (f == 3'b100) || (f == 3'b110);
        rem = (f == 3'b110) || (f == 3'b111);
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return rem ? r[31:0] : q[31:0];
    endfunction

    // Transaction model: busy, countdown to the done cycle, and the architecturally visible result.
    bit          m_busy [2];
    int          m_cd   [2];
    logic [31:0] m_res  [2];
    logic [4:0]  m_rd   [2];
    logic [31:0] p_res  [2];
    logic [4:0]  p_rd   [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0;
                m_cd[d]   <= 0;
                m_res[d]  <= '0;
                m_rd[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_busy[d]) begin
                    if (flush_s[d] || m_cd[d] == 0) begin
                        m_busy[d] <= 1'b0;
                    end else begin
                        m_cd[d] <= m_cd[d] - 1;
                        if (m_cd[d] == 1) begin
                            m_res[d] <= p_res[d];
                            m_rd[d]  <= p_rd[d];
                        end
                    end
                end else if (start_s[d] && !flush_s[d]) begin
                    m_busy[d] <= 1'b1;
                    if (is_special(f3_s[d], a_s[d], b_s[d])) begin
                        m_cd[d]  <= 0;
                        m_res[d] <= ref_div(f3_s[d], a_s[d], b_s[d]);
                        m_rd[d]  <= rd_s[d];
                    end else begin
                        m_cd[d]  <= calc_cycles(d);
                        p_res[d] <= ref_div(f3_s[d], a_s[d], b_s[d]);
                        p_rd[d]  <= rd_s[d];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy[%0d]", d), {31'd0, busy_o[d]}, {31'd0, m_busy[d]});
            chk($sformatf("done[%0d]", d), {31'd0, done_o[d]},
                {31'd0, m_busy[d] && m_cd[d] == 0 && !flush_s[d]});
            chk($sformatf("result[%0d]", d), result_o[d], m_res[d]);
            chk($sformatf("rd_out[%0d]", d), {27'd0, rd_o[d]}, {27'd0, m_rd[d]});
        end
    end

    // Issue one op from IDLE (called at posedge+1), wait for done, check literal result and latency.
    task automatic run_op(input int d, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                          input bit noise);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        start_s[d] = 1'b1;
        f3_s[d] = f;
        a_s[d] = a;
        b_s[d] = b;
        rd_s[d] = rd;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (k == 0) start_s[d] = 1'b0;
            if (noise && lat == 5) begin
                start_s[d] = 1'b1;
                f3_s[d] = 3'($urandom);
                a_s[d] = $urandom;
                b_s[d] = $urandom;
                rd_s[d] = 5'($urandom);
            end else if (noise && lat == 6) begin
                start_s[d] = 1'b0;
            end
            if (done_o[d]) got = 1'b1;
        end
        chk($sformatf("done_seen[%0d]", d), {31'd0, got}, 32'd1);
        chk($sformatf("latency[%0d]", d), lat, exp_lat);
        chk($sformatf("op_result[%0d] f=%b a=%h b=%h", d, f, a, b), result_o[d], exp_res);
        chk($sformatf("op_rd[%0d]", d), {27'd0, rd_o[d]}, {27'd0, rd});
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int d);
        logic [2:0]  f;
        logic [31:0] a, b;
        int          sel, lat;
        bit          sp;
        f   = 3'($urandom_range(0, 7));
        a   = $urandom;
        b   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) b = 32'd0;
        else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        else if (sel == 2) b = $urandom_range(1, 15);
        else if (sel == 3) a = $urandom_range(0, 100);
        else if (sel == 4) b = -$urandom_range(1, 15);
        sp  = is_special(f, a, b);
        lat = sp ? 1 : calc_cycles(d) + 1;
        run_op(d, f, a, b, 5'($urandom), ref_div(f, a, b), lat, !sp && ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; flush_s[d] = 1'b0; f3_s[d] = '0;
            a_s[d] = '0; b_s[d] = '0; rd_s[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy_o[0]}, 32'd0);
        chk("reset_done", {31'd0, done_o[0]}, 32'd0);
        chk("reset_result", result_o[0], 32'd0);
        chk("reset_rd", {27'd0, rd_o[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op(0, 3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 33, 1'b0);
        run_op(0, 3'b111, 32'd100, 32'd7, 5'd4, 32'd2, 33, 1'b0);
        run_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, 1'b0);
        run_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 1'b0);
        run_op(0, 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 33, 1'b0);
        run_op(0, 3'b100, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, 1'b0);
        run_op(0, 3'b111, 32'd5, 32'd0, 5'd9, 32'd5, 1, 1'b0);
        run_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, 1'b0);
        run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1, 1'b0);
        run_op(0, 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 33, 1'b1);
        run_op(0, 3'b010, 32'd45, 32'd6, 5'd13, 32'd7, 33, 1'b0);

        // Flush during CALC cycle 10, then confirm nothing is reported.
        start_s[0] = 1'b1; f3_s[0] = 3'b101; a_s[0] = 32'd1000; b_s[0] = 32'd3; rd_s[0] = 5'd20;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_s[0] = 1'b1;
        @(posedge clk);
        #1;
        flush_s[0] = 1'b0;
        chk("flush_busy_low", {31'd0, busy_o[0]}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o[0]) seen_done = 1'b1;
        end
        chk("flush_no_done", {31'd0, seen_done}, 32'd0);
        chk("flush_result_kept", result_o[0], 32'd7);
        run_op(0, 3'b101, 32'd1000, 32'd3, 5'd21, 32'd333, 33, 1'b0);

        // Reset asserted mid-CALC clears busy/done without waiting for a clock.
        start_s[0] = 1'b1; f3_s[0] = 3'b100; a_s[0] = 32'd99; b_s[0] = 32'd4; rd_s[0] = 5'd22;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy_o[0]}, 32'd0);
        chk("async_rst_done", {31'd0, done_o[0]}, 32'd0);
        chk("async_rst_result", result_o[0], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op(1, 3'b101, 32'd100, 32'd7, 5'd1, 32'd14, 9, 1'b0);
        run_op(1, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 9, 1'b1);
        run_op(1, 3'b101, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, 1, 1'b0);

        for (int i = 0; i < 60; i++) run_random(0);
        for (int i = 0; i < 40; i++) run_random(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
